// File: rtl/oven_ctrl.sv
// Microwave oven controller: cook-time entry by short presses, start/cancel by
// long press, door-interlocked pause, and a timed done indication.
module oven_ctrl #(
  parameter int SECONDS  = 50_000_000,
  parameter int ADD_SEC  = 30,
  parameter int MAX_SEC  = 999,
  parameter int BEEP_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       short_in,
  input  logic       long_in,
  input  logic       door,
  output logic       heater,
  output logic       done,
  output logic [9:0] remaining,
  output logic [2:0] state
);

  localparam int PW = (SECONDS > 1) ? $clog2(SECONDS) : 1;
  localparam int BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam logic [PW-1:0] TICK_V = PW'(SECONDS - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);
  localparam logic [9:0] ADD_V = 10'(ADD_SEC);
  localparam logic [9:0] MAX_V = 10'(MAX_SEC);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      rem_q, rem_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   beep_q, beep_d;
  logic            tick;
  logic [9:0]      rem_dec;

  // Saturating add of one press worth of seconds; computed one bit wider so it never wraps.
  function automatic logic [9:0] sat_add(input logic [9:0] a);
    logic [10:0] sum;
    sum = {1'b0, a} + {1'b0, ADD_V};
    return (sum > {1'b0, MAX_V}) ? MAX_V : sum[9:0];
  endfunction

  assign tick      = (presc_q == TICK_V);
  assign rem_dec   = rem_q - 10'd1;
  assign heater    = (state_q == COOK);
  assign done      = (state_q == DONE);
  assign remaining = rem_q;
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      presc_q <= '0;
      beep_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      beep_q  <= beep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    beep_d  = beep_q;
    unique case (state_q)
      IDLE: begin
        rem_d   = '0;
        presc_d = '0;
        beep_d  = '0;
        if (short_in) begin
          state_d = SET;
          rem_d   = sat_add(10'd0);
        end
      end
      SET: begin
        if (long_in) begin
          if (!door) begin
            state_d = COOK;
            presc_d = '0;
          end
        end else if (short_in) begin
          rem_d = sat_add(rem_q);
        end
      end
      COOK: begin
        if (long_in) begin
          state_d = IDLE;
          rem_d   = '0;
          presc_d = '0;
        end else if (door) begin
          // Prescaler holds on the way into PAUSE so no part of a second is lost.
          state_d = PAUSE;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (rem_q == 10'd1 && !short_in) begin
              state_d = DONE;
              rem_d   = '0;
              presc_d = '0;
              beep_d  = '0;
            end else begin
              rem_d = short_in ? sat_add(rem_dec) : rem_dec;
            end
          end else if (short_in) begin
            rem_d = sat_add(rem_q);
          end
        end
      end
      PAUSE: begin
        if (long_in) begin
          state_d = IDLE;
          rem_d   = '0;
          presc_d = '0;
        end else if (short_in && !door) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (short_in || long_in) begin
          state_d = IDLE;
          presc_d = '0;
          beep_d  = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (beep_q == BEEP_LAST) begin
              state_d = IDLE;
              presc_d = '0;
              beep_d  = '0;
            end else begin
              beep_d = beep_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
        presc_d = '0;
        beep_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_oven_ctrl.sv
// Testbench for oven_ctrl: directed scenarios followed by random button/door
// traffic, all checked against a behavioural model of the oven rules.
module tb_oven_ctrl;

  localparam int SECONDS  = 4;
  localparam int ADD_SEC  = 3;
  localparam int MAX_SEC  = 7;
  localparam int BEEP_SEC = 2;

  localparam int S_IDLE  = 0;
  localparam int S_SET   = 1;
  localparam int S_COOK  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       short_in = 1'b0;
  logic       long_in = 1'b0;
  logic       door = 1'b0;
  logic       heater;
  logic       done;
  logic [9:0] remaining;
  logic [2:0] state;

  int checkCount = 0;
  int failCount  = 0;

  int mState = S_IDLE;
  int mRem   = 0;
  int mPre   = 0;
  int mBeep  = 0;

  oven_ctrl #(
    .SECONDS(SECONDS), .ADD_SEC(ADD_SEC), .MAX_SEC(MAX_SEC), .BEEP_SEC(BEEP_SEC)
  ) dut (
    .clk(clk), .rst(rst), .short_in(short_in), .long_in(long_in), .door(door),
    .heater(heater), .done(done), .remaining(remaining), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int satAdd(input int a);
    return (a + ADD_SEC > MAX_SEC) ? MAX_SEC : a + ADD_SEC;
  endfunction

  task automatic modelReset();
    mState = S_IDLE;
    mRem   = 0;
    mPre   = 0;
    mBeep  = 0;
  endtask

  // One clock of the oven rules, written in terms of seconds and cycle counts.
  task automatic modelStep(input bit s, input bit l, input bit d);
    bit secondEnds;
    secondEnds = (mPre == SECONDS - 1);
    if (mState == S_IDLE) begin
      if (s) begin
        mState = S_SET;
        mRem   = satAdd(0);
      end
    end else if (mState == S_SET) begin
      if (l && !d) begin
        mState = S_COOK;
        mPre   = 0;
      end else if (!l && s) begin
        mRem = satAdd(mRem);
      end
    end else if (mState == S_COOK) begin
      if (l) begin
        mState = S_IDLE;
        mRem   = 0;
        mPre   = 0;
      end else if (d) begin
        mState = S_PAUSE;
      end else begin
        mPre = (mPre + 1) % SECONDS;
        if (secondEnds) mRem = mRem - 1;
        if (secondEnds && mRem == 0 && !s) begin
          mState = S_DONE;
          mPre   = 0;
          mBeep  = 0;
        end else if (s) begin
          mRem = satAdd(mRem);
        end
      end
    end else if (mState == S_PAUSE) begin
      if (l) begin
        mState = S_IDLE;
        mRem   = 0;
        mPre   = 0;
      end else if (s && !d) begin
        mState = S_COOK;
      end
    end else begin
      if (s || l) begin
        mState = S_IDLE;
        mPre   = 0;
        mBeep  = 0;
      end else begin
        mPre = (mPre + 1) % SECONDS;
        if (secondEnds) begin
          mBeep = mBeep + 1;
          if (mBeep == BEEP_SEC) begin
            mState = S_IDLE;
            mPre   = 0;
            mBeep  = 0;
          end
        end
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".state"}, 16'(state), 16'(mState));
    checkValue({tag, ".remaining"}, 16'(remaining), 16'(mRem));
    checkValue({tag, ".heater"}, 16'(heater), 16'(mState == S_COOK));
    checkValue({tag, ".done"}, 16'(done), 16'(mState == S_DONE));
  endtask

  task automatic applyStimulus(input bit s, input bit l, input bit d, input string tag);
    short_in = s;
    long_in  = l;
    door     = d;
    @(posedge clk);
    modelStep(s, l, d);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input bit d, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, d, tag);
  endtask

  initial begin
    bit rs, rl, rd;

    #3;
    checkValue("reset.state", 16'(state), 16'(S_IDLE));
    checkValue("reset.remaining", 16'(remaining), 16'd0);
    checkValue("reset.heater", 16'(heater), 16'd0);
    checkValue("reset.done", 16'(done), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();

    // Basic cook: 3 seconds, then the done indication for two seconds.
    applyStimulus(1'b1, 1'b0, 1'b0, "basic.short");
    applyStimulus(1'b0, 1'b1, 1'b0, "basic.start");
    checkValue("basic.startState", 16'(state), 16'(S_COOK));
    idleCycles(4, 1'b0, "basic.sec1");
    checkValue("basic.rem2", 16'(remaining), 16'd2);
    idleCycles(4, 1'b0, "basic.sec2");
    checkValue("basic.rem1", 16'(remaining), 16'd1);
    idleCycles(4, 1'b0, "basic.sec3");
    checkValue("basic.doneState", 16'(state), 16'(S_DONE));
    checkValue("basic.rem0", 16'(remaining), 16'd0);
    idleCycles(7, 1'b0, "basic.beep");
    checkValue("basic.stillDone", 16'(done), 16'd1);
    idleCycles(1, 1'b0, "basic.beepEnd");
    checkValue("basic.backIdle", 16'(state), 16'(S_IDLE));

    // Saturation at MAX_SEC, then a blocked start with the door open.
    applyStimulus(1'b1, 1'b0, 1'b0, "sat.p1");
    checkValue("sat.rem3", 16'(remaining), 16'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, "sat.p2");
    checkValue("sat.rem6", 16'(remaining), 16'd6);
    applyStimulus(1'b1, 1'b0, 1'b0, "sat.p3");
    checkValue("sat.rem7", 16'(remaining), 16'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, "doorSet.long");
    checkValue("doorSet.state", 16'(state), 16'(S_SET));
    checkValue("doorSet.heater", 16'(heater), 16'd0);

    // Door opened mid-cook, held, closed, then resumed with a short press.
    applyStimulus(1'b0, 1'b1, 1'b0, "pause.start");
    idleCycles(6, 1'b0, "pause.cook");
    applyStimulus(1'b0, 1'b0, 1'b1, "pause.open");
    checkValue("pause.state", 16'(state), 16'(S_PAUSE));
    checkValue("pause.heater", 16'(heater), 16'd0);
    idleCycles(5, 1'b1, "pause.held");
    applyStimulus(1'b1, 1'b0, 1'b1, "pause.shortDoorOpen");
    idleCycles(2, 1'b0, "pause.closed");
    applyStimulus(1'b1, 1'b0, 1'b0, "pause.resume");
    idleCycles(6, 1'b0, "pause.after");

    // Simultaneous long and short cancels the cook.
    applyStimulus(1'b1, 1'b1, 1'b0, "both.cancel");
    checkValue("both.state", 16'(state), 16'(S_IDLE));
    checkValue("both.rem", 16'(remaining), 16'd0);

    // Extending on the final tick keeps cooking with a fresh ADD_SEC.
    applyStimulus(1'b1, 1'b0, 1'b0, "ext.short");
    applyStimulus(1'b0, 1'b1, 1'b0, "ext.start");
    idleCycles(11, 1'b0, "ext.run");
    applyStimulus(1'b1, 1'b0, 1'b0, "ext.lastTick");
    checkValue("ext.rem3", 16'(remaining), 16'd3);
    checkValue("ext.state", 16'(state), 16'(S_COOK));

    // Asynchronous reset mid-cook, then no resume after release.
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    checkValue("rstMid.state", 16'(state), 16'(S_IDLE));
    checkValue("rstMid.remaining", 16'(remaining), 16'd0);
    checkValue("rstMid.heater", 16'(heater), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, "rstMid.long");
    checkValue("rstMid.noResume", 16'(state), 16'(S_IDLE));

    // Random button and door traffic against the model.
    rd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 4) == 0);
      rl = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) rd = ~rd;
      applyStimulus(rs, rl, rd, "rand");
    end

    $display("[TB] %0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/oven_ctrl.md
OVEN_CTRL -- requirements
Module: oven_ctrl

Interface
REQ-001 SHALL have parameter SECONDS, default 50_000_000: clock cycles per second tick.
REQ-002 SHALL have parameter ADD_SEC, default 30: seconds added per short press.
REQ-003 SHALL have parameter MAX_SEC, default 999: saturation limit of the cook time.
REQ-004 SHALL have parameter BEEP_SEC, default 3: seconds the done indication is held.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port short_in, input, 1 bit: one-cycle short-press pulse from the button classifier.
REQ-008 SHALL have port long_in, input, 1 bit: one-cycle long-press pulse from the button classifier.
REQ-009 SHALL have port door, input, 1 bit, synchronous to clk: door level, 1 = open.
REQ-010 SHALL have port heater, output, 1 bit: magnetron enable.
REQ-011 SHALL have port done, output, 1 bit: cook-finished indication.
REQ-012 SHALL have port remaining, output, 10 bits: remaining cook seconds, unsigned.
REQ-013 SHALL have port state, output, 3 bits: encoding IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.

Function
REQ-014 SHALL derive heater and done combinationally from the state register only: heater=1 iff COOK; done=1 iff DONE.
REQ-015 SHALL keep a one-second prescaler counting 0..SECONDS-1; a tick is the cycle it equals SECONDS-1, after which it returns to 0.
REQ-016 SHALL advance the prescaler only in COOK and DONE; it holds in PAUSE and clears to 0 on any entry to COOK from SET, and on entry to DONE.
REQ-017 SHALL give long_in priority over short_in when both are high in the same cycle; short_in is then ignored.
REQ-018 SHALL add time as remaining = min(remaining + ADD_SEC, MAX_SEC), never wrapping.
REQ-019 IDLE: remaining=0; short_in -> SET with remaining=ADD_SEC; long_in ignored.
REQ-020 SET: short_in adds time; long_in with door=0 -> COOK; long_in with door=1 -> stay in SET.
REQ-021 COOK: long_in -> IDLE with remaining=0 (cancel). Otherwise door=1 -> PAUSE, and no decrement occurs that cycle.
REQ-022 COOK, door=0, no long_in: on a tick, remaining decrements by 1; a short_in in that cycle adds time after the decrement.
REQ-023 COOK: a tick with remaining=1 and no short_in -> DONE with remaining=0; with short_in -> remaining=ADD_SEC, stay in COOK.
REQ-024 PAUSE: long_in -> IDLE with remaining=0; short_in with door=0 -> COOK, prescaler resumes its held value; short_in with door=1 is ignored.
REQ-025 DONE: short_in or long_in -> IDLE; otherwise -> IDLE after BEEP_SEC ticks.
REQ-026 SHALL never enter COOK with remaining=0 and never drive heater while door=1 for more than the one cycle of REQ-021 latency.

Reset
REQ-027 SHALL on rst=0, immediately and irrespective of clk: state=IDLE, remaining=0, prescaler=0, beep counter=0, heater=0, done=0.
REQ-028 SHALL abort any cook immediately on reset mid-operation, dropping heater in the same instant with no resume after release.
REQ-029 SHALL take its first transition on the first rising clk edge with rst=1.

Verification (SECONDS=4, ADD_SEC=3, MAX_SEC=7, BEEP_SEC=2)
REQ-030 SHALL cover a basic cook: short, long with door=0 -> state COOK; remaining 3,2,1,0 at 4-cycle intervals; DONE for 8 cycles -> IDLE.
REQ-031 SHALL cover saturation: short x3 in SET -> remaining 3, 6, 7 (not 9).
REQ-032 SHALL cover door handling: door=1 mid-COOK -> PAUSE next cycle and heater=0; remaining frozen. Then door=0 and short -> COOK, with the tick at the held prescaler phase.
REQ-033 SHALL cover simultaneous events: long and short together in COOK -> IDLE, remaining=0. A tick with remaining=1 plus short -> remaining=3, still COOK.
REQ-034 SHALL cover a long press in SET with door=1 -> stays in SET, heater=0.
REQ-035 SHALL cover reset mid-COOK: rst=0 -> state 0, remaining 0, heater 0 asynchronously; after release, long_in -> no change.
